adder_arbiter: RTL

Round-robin arbiter that shares one two-stage 32-bit adder pipeline among NUM_REQ requesters. Each requester presents an operand pair under a valid/ready handshake. At most one pair is granted per cycle, tagged with the requester index and pushed through an operand stage and a sum stage. The tagged 33-bit sum is returned on a single result port with backpressure. The block sits between several client engines and the shared adder datapath.

---
 rtl/adder_arbiter.sv | 112 +++++++++++
 1 files changed

// File: rtl/adder_arbiter.sv
// Round-robin arbiter feeding a shared two-stage adder pipeline (operand stage, sum stage).
// Results carry the requester index and leave in grant order under res_ready backpressure.
module adder_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [ID_W-1:0]          res_id,
  output logic [WIDTH:0]           res_sum
);

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [ID_W-1:0]  s1_id;
  logic             s2_valid;
  logic [WIDTH:0]   s2_sum;
  logic [ID_W-1:0]  s2_id;
  logic [ID_W-1:0]  ptr;

  logic             s1_adv;
  logic             s2_adv;
  logic             found;
  logic [ID_W-1:0]  winner;
  logic [ID_W:0]    cand;
  logic             grant;
  logic [ID_W-1:0]  next_ptr;

  assign s2_adv = !s2_valid || res_ready;
  assign s1_adv = !s1_valid || s2_adv;

  // Search ptr, ptr+1, ... modulo NUM_REQ for the first valid requester.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr} + (ID_W+1)'(k);
      if (cand >= (ID_W+1)'(NUM_REQ)) begin
        cand = cand - (ID_W+1)'(NUM_REQ);
      end else begin
        cand = cand;
      end
      if (!found && req_valid[cand[ID_W-1:0]]) begin
        found  = 1'b1;
        winner = cand[ID_W-1:0];
      end else begin
        found  = found;
        winner = winner;
      end
    end
  end

  // Grant is gated by reset so req_ready reads zero while reset is held.
  always_comb begin
    grant     = found && s1_adv && !reset;
    req_ready = '0;
    if (grant) begin
      req_ready[winner] = 1'b1;
    end else begin
      req_ready = '0;
    end
    // Explicit wrap keeps non-power-of-two NUM_REQ from reaching unused indices.
    if (winner == ID_W'(NUM_REQ-1)) begin
      next_ptr = '0;
    end else begin
      next_ptr = winner + 1'b1;
    end
  end

  // Pipeline stages and round-robin pointer.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_id    <= '0;
      s2_valid <= 1'b0;
      s2_sum   <= '0;
      s2_id    <= '0;
      ptr      <= '0;
    end else begin
      if (s2_adv) begin
        s2_valid <= s1_valid;
        s2_sum   <= {1'b0, s1_a} + {1'b0, s1_b};
        s2_id    <= s1_id;
      end
      if (s1_adv) begin
        s1_valid <= grant;
        if (grant) begin
          s1_a  <= req_a[winner*WIDTH +: WIDTH];
          s1_b  <= req_b[winner*WIDTH +: WIDTH];
          s1_id <= winner;
          ptr   <= next_ptr;
        end
      end
    end
  end

  assign res_valid = s2_valid;
  assign res_sum   = s2_sum;
  assign res_id    = s2_id;

endmodule
